seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the same 4-bit op encoding and 8-bit status byte.
- Replaces combinational multiply/divide with iterative shift-add and restoring units.
- Sits in the EX stage behind a valid/ready handshake; the pipeline stalls while it is busy.

Parameters:
- WIDTH, 32: operand/result width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  op/a/b are valid this cycle.
- in_ready  out  1  block can accept an op this cycle.
- control  in  4  op code (encoding below).
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- out_valid  out  1  result_out/status_out are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result_out  out  WIDTH  result.
- status_out  out  8  flags: [7] zero, [6] overflow, [5] carry, [4] negative, [3] align, [2] div-by-zero, [1:0] always 0.

Behaviour:
- Op encoding:
  - 0 AND, 1 OR, 10 XOR, 11 NOR.
  - 2 ADD, 6 SUB.
  - 5 MUL (signed, low half), 4 DIV (signed quotient, truncate toward zero).
  - 12 ADD-aligned-check, 13 ADD-misaligned-check.
  - 7 SLT (result 1 if a<b signed, else 0).
  - 8 SLL, 9 SRL (logical; shift amount is b as unsigned; ≥WIDTH gives 0).
  - Other codes: result 0.
- Status rules:
  - [7] = (result==0) for every op, including undefined codes (status 8'h80).
  - [4] = result MSB for ops 2,6,5,4,12,13,7; otherwise 0.
  - [5] = carry/borrow-out bit of WIDTH+1-bit unsigned a+b (op 2) or a-b (op 6); otherwise 0.
  - [3]: op 2 and 12 → 1 when result[1:0]==0; op 13 → 1 when result[1:0]!=0; otherwise 0.
  - [6]: MUL → 1 when upper WIDTH bits of the 2*WIDTH product are nonzero (so negative products also flag); DIV → 1 for MIN/-1 (quotient = MIN); otherwise 0.
  - [2]: DIV with b==0 → 1, result 0.
- FSM states:
  - IDLE: in_ready=1; on in_valid latch control/a/b. MUL, or DIV with b!=0, → BUSY with counter=0; all others compute → DONE.
  - BUSY: one partial-product or restoring step per cycle; after WIDTH steps, sign-fix and → DONE.
  - DONE: out_valid=1, outputs held stable; on out_ready → IDLE.
- Latency: single-cycle ops and DIV-by-zero give out_valid the cycle after acceptance (1). MUL/DIV take WIDTH+1 cycles. Throughput is one op per (latency+1) minimum; in_ready=0 in BUSY and DONE.
- Inputs are ignored when in_ready=0; operands are captured at acceptance, so later changes to a/b have no effect.
- Reset:
  - Any state → IDLE next edge; in-flight op discarded, no result emitted.
  - Reset values: result_out=0, status_out=0, out_valid=0, in_ready=1 in the cycle after rst deasserts.
- out_ready with out_valid=0 has no effect.

Optional Feature:
- SEQ_ALU_HI_EN defined:
  - Adds port hi_out (out, WIDTH), valid alongside out_valid.
  - MUL: upper WIDTH bits of the product. DIV: signed remainder with the sign of a; 0 on div-by-zero.
  - All other ops: 0. Reset value 0.
- Not defined: port absent; remainder/high-half registers are not kept beyond what the iteration needs.

Test Plan (WIDTH=32):
- ADD a=32'h7FFF_FFFC, b=4 → 1 cycle later: result 32'h8000_0000, status 8'h18 ([4],[3]); ADD a=-1, b=1 → result 0, status 8'hA8.
- MUL a=-3, b=7 → out_valid exactly 33 cycles after acceptance; result -21, status 8'h50. MUL 65536×65536 → result 0, status 8'hC0. Check in_ready=0 throughout.
- DIV a=-7, b=2 → result -3 after 33 cycles (hi_out=-1 with SEQ_ALU_HI_EN). DIV b=0 → 1-cycle, result 0, status 8'h84. DIV 32'h8000_0000/-1 → result 32'h8000_0000, status 8'h50.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, new in_valid ignored; out_ready=1 → IDLE next cycle, then next op accepted.
- Assert rst at cycle 10 of a MUL → next edge out_valid=0, result/status 0, in_ready=1; fresh SLT a=-1, b=0 → result 1, status 8'h00.
- Shifts/undefined: SLL a=1, b=40 → 0, status 8'h80. SRL a=32'h8000_0000, b=31 → 1. control=15 → result 0, status 8'h80.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV
// behind a valid/ready handshake. Define SEQ_ALU_HI_EN to add hi_out (MUL high half / DIV remainder).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_out,
    output logic [7:0]       status_out
`ifdef SEQ_ALU_HI_EN
    ,
    output logic [WIDTH-1:0] hi_out
`endif
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_ADDA = 4'd12;
    localparam logic [3:0] OP_ADDM = 4'd13;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [7:0]         status_q, status_d;
`ifdef SEQ_ALU_HI_EN
    logic               a_neg_q, a_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   hi_v;
    logic [WIDTH-1:0]   div_rem;
`endif

    logic [3:0]         op_sel;
    logic               fire, carry, ovf, dbz, neg_flag, align_flag;
    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_v, mul_acc, shl, div_acc;
    logic [WIDTH-1:0]   mul_qr, div_qr, div_quo;
    logic [2*WIDTH-1:0] mul_prod, mul_fix;
    logic               ge;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign a_mag    = a[WIDTH-1] ? -a : a;
    assign b_mag    = b[WIDTH-1] ? -b : b;

    // Iteration works on magnitudes; {acc, qr} is the double-width product/remainder:quotient pair.
    assign add_v    = acc_q + {1'b0, (qr_q[0] ? m_q : '0)};
    assign mul_acc  = {1'b0, add_v[WIDTH:1]};
    assign mul_qr   = {add_v[0], qr_q[WIDTH-1:1]};
    assign mul_prod = {mul_acc[WIDTH-1:0], mul_qr};
    assign mul_fix  = neg_q ? -mul_prod : mul_prod;

    assign shl      = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    assign ge       = (shl >= {1'b0, m_q});
    assign div_acc  = ge ? (shl - {1'b0, m_q}) : shl;
    assign div_qr   = {qr_q[WIDTH-2:0], ge};
    assign div_quo  = neg_q ? -div_qr : div_qr;
`ifdef SEQ_ALU_HI_EN
    assign div_rem  = a_neg_q ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
`endif

    assign op_sel     = (state_q == S_IDLE) ? control : op_q;
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign result_out = result_q;
    assign status_out = status_q;
`ifdef SEQ_ALU_HI_EN
    assign hi_out     = hi_q;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        m_d      = m_q;
        qr_d     = qr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        status_d = status_q;
`ifdef SEQ_ALU_HI_EN
        a_neg_d  = a_neg_q;
        hi_d     = hi_q;
        hi_v     = '0;
`endif
        fire       = 1'b0;
        res        = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        dbz        = 1'b0;
        neg_flag   = 1'b0;
        align_flag = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = control;
                    if (control == OP_MUL || (control == OP_DIV && b != '0)) begin
                        neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_BUSY;
`ifdef SEQ_ALU_HI_EN
                        a_neg_d = a[WIDTH-1];
`endif
                        if (control == OP_MUL) begin
                            m_d  = a_mag;
                            qr_d = b_mag;
                        end else begin
                            m_d  = b_mag;
                            qr_d = a_mag;
                        end
                    end else begin
                        fire    = 1'b1;
                        state_d = S_DONE;
                        case (control)
                            OP_AND:           res = a & b;
                            OP_OR:            res = a | b;
                            OP_XOR:           res = a ^ b;
                            OP_NOR:           res = ~(a | b);
                            OP_ADD: begin
                                res   = sum_ext[WIDTH-1:0];
                                carry = sum_ext[WIDTH];
                            end
                            OP_SUB: begin
                                res   = diff_ext[WIDTH-1:0];
                                carry = diff_ext[WIDTH];
                            end
                            OP_ADDA, OP_ADDM: res = sum_ext[WIDTH-1:0];
                            OP_SLT:           res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                            OP_SLL:           res = a << b;
                            OP_SRL:           res = a >> b;
                            OP_DIV:           dbz = 1'b1;
                            default:          res = '0;
                        endcase
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    qr_d  = mul_qr;
                end else begin
                    acc_d = div_acc;
                    qr_d  = div_qr;
                end
                if (cnt_q == LAST) begin
                    fire    = 1'b1;
                    state_d = S_DONE;
                    if (op_q == OP_MUL) begin
                        res = mul_fix[WIDTH-1:0];
                        ovf = |mul_fix[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_HI_EN
                        hi_v = mul_fix[2*WIDTH-1:WIDTH];
`endif
                    end else begin
                        res = div_quo;
                        // A positive quotient with MSB set only arises from MIN / -1.
                        ovf = ~neg_q & div_qr[WIDTH-1];
`ifdef SEQ_ALU_HI_EN
                        hi_v = div_rem;
`endif
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case (op_sel)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ADDA, OP_ADDM, OP_SLT: neg_flag = res[WIDTH-1];
            default: neg_flag = 1'b0;
        endcase
        case (op_sel)
            OP_ADD, OP_ADDA: align_flag = (res[1:0] == 2'b00);
            OP_ADDM:         align_flag = (res[1:0] != 2'b00);
            default:         align_flag = 1'b0;
        endcase

        if (fire) begin
            result_d = res;
            status_d = {(res == '0), ovf, carry, neg_flag, align_flag, dbz, 2'b00};
`ifdef SEQ_ALU_HI_EN
            hi_d     = hi_v;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            qr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            status_q <= '0;
`ifdef SEQ_ALU_HI_EN
            a_neg_q  <= 1'b0;
            hi_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            m_q      <= m_d;
            qr_q     <= qr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            status_q <= status_d;
`ifdef SEQ_ALU_HI_EN
            a_neg_q  <= a_neg_d;
            hi_q     <= hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); hi_out checks appear when SEQ_ALU_HI_EN is defined.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  control = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result_out;
    logic [7:0]  status_out;
`ifdef SEQ_ALU_HI_EN
    logic [31:0] hi_out;
`endif

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .control    (control),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .status_out (status_out)
`ifdef SEQ_ALU_HI_EN
        ,
        .hi_out     (hi_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for out_valid, capture outputs, then consume the result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output logic [31:0] res, output logic [7:0] st,
                         output logic rdy_seen);
        control  = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        res = result_out;
        st  = status_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result_out); end
        checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", status_out); end
    endtask

    task automatic test_single_cycle();
        int lat; logic [31:0] r; logic [7:0] s; logic rs;
        do_op(4'd2, 32'h7FFF_FFFC, 32'd4, lat, r, s, rs);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add1_latency got %0d want 1", lat); end
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL add1_result got %h want 80000000", r); end
        checks++; if (s !== 8'h18) begin errors++; $display("FAIL add1_status got %h want 18", s); end
        do_op(4'd2, 32'hFFFF_FFFF, 32'd1, lat, r, s, rs);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL add2_result got %h want 0", r); end
        checks++; if (s !== 8'hA8) begin errors++; $display("FAIL add2_status got %h want a8", s); end
        do_op(4'd6, 32'd3, 32'd5, lat, r, s, rs);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result got %h want fffffffe", r); end
        checks++; if (s !== 8'h30) begin errors++; $display("FAIL sub_status got %h want 30", s); end
        do_op(4'd10, 32'h0000_F0F0, 32'h0000_FF00, lat, r, s, rs);
        checks++; if (r !== 32'h0000_0FF0) begin errors++; $display("FAIL xor_result got %h want 00000ff0", r); end
        do_op(4'd11, 32'h0, 32'h0, lat, r, s, rs);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nor_result got %h want ffffffff", r); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL nor_status got %h want 00", s); end
        do_op(4'd1, 32'h0000_00A0, 32'h0000_0005, lat, r, s, rs);
        checks++; if (r !== 32'h0000_00A5) begin errors++; $display("FAIL or_result got %h want 000000a5", r); end
        do_op(4'd12, 32'd1, 32'd2, lat, r, s, rs);
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL adda_status got %h want 00", s); end
        do_op(4'd13, 32'd1, 32'd2, lat, r, s, rs);
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL addm_result got %h want 3", r); end
        checks++; if (s !== 8'h08) begin errors++; $display("FAIL addm_status got %h want 08", s); end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] r; logic [7:0] s; logic rs;
        do_op(4'd5, 32'hFFFF_FFFD, 32'd7, lat, r, s, rs);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul1_latency got %0d want 33", lat); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul1_in_ready_busy got %b want 0", rs); end
        checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul1_result got %h want ffffffeb", r); end
        checks++; if (s !== 8'h50) begin errors++; $display("FAIL mul1_status got %h want 50", s); end
`ifdef SEQ_ALU_HI_EN
        checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul1_hi got %h want ffffffff", hi_out); end
`endif
        do_op(4'd5, 32'h0001_0000, 32'h0001_0000, lat, r, s, rs);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mul2_result got %h want 0", r); end
        checks++; if (s !== 8'hC0) begin errors++; $display("FAIL mul2_status got %h want c0", s); end
`ifdef SEQ_ALU_HI_EN
        checks++; if (hi_out !== 32'h1) begin errors++; $display("FAIL mul2_hi got %h want 1", hi_out); end
`endif
    endtask

    task automatic test_div();
        int lat; logic [31:0] r; logic [7:0] s; logic rs;
        do_op(4'd4, 32'hFFFF_FFF9, 32'd2, lat, r, s, rs);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div1_latency got %0d want 33", lat); end
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div1_result got %h want fffffffd", r); end
        checks++; if (s !== 8'h10) begin errors++; $display("FAIL div1_status got %h want 10", s); end
`ifdef SEQ_ALU_HI_EN
        checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div1_hi got %h want ffffffff", hi_out); end
`endif
        do_op(4'd4, 32'd100, 32'd7, lat, r, s, rs);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL div2_result got %h want 0000000e", r); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL div2_status got %h want 00", s); end
        do_op(4'd4, 32'd55, 32'd0, lat, r, s, rs);
        checks++; if (lat !== 1) begin errors++; $display("FAIL divz_latency got %0d want 1", lat); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL divz_result got %h want 0", r); end
        checks++; if (s !== 8'h84) begin errors++; $display("FAIL divz_status got %h want 84", s); end
        do_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, s, rs);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL divmin_result got %h want 80000000", r); end
        checks++; if (s !== 8'h50) begin errors++; $display("FAIL divmin_status got %h want 50", s); end
    endtask

    task automatic test_backpressure();
        control  = 4'd2;
        a        = 32'd1;
        b        = 32'd2;
        in_valid = 1'b1;
        tick();
        control  = 4'd5;
        a        = 32'd9;
        b        = 32'd9;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            checks++; if (result_out !== 32'd3) begin errors++; $display("FAIL bp_result got %h want 3", result_out); end
            checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL bp_status got %h want 00", status_out); end
            tick();
        end
        control   = 4'd0;
        a         = 32'h0000_00FF;
        b         = 32'h0000_000F;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
        checks++; if (result_out !== 32'h0000_000F) begin errors++; $display("FAIL bp_next_result got %h want 0000000f", result_out); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic [31:0] r; logic [7:0] s; logic rs;
        control  = 4'd5;
        a        = 32'd12345;
        b        = 32'd678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", result_out); end
        checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL rstmid_status got %h want 00", status_out); end
        do_op(4'd7, 32'hFFFF_FFFF, 32'd0, lat, r, s, rs);
        checks++; if (lat !== 1) begin errors++; $display("FAIL slt_latency got %0d want 1", lat); end
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL slt_result got %h want 1", r); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL slt_status got %h want 00", s); end
    endtask

    task automatic test_shift_undef();
        int lat; logic [31:0] r; logic [7:0] s; logic rs;
        do_op(4'd8, 32'd1, 32'd40, lat, r, s, rs);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL sll40_result got %h want 0", r); end
        checks++; if (s !== 8'h80) begin errors++; $display("FAIL sll40_status got %h want 80", s); end
        do_op(4'd8, 32'd1, 32'd31, lat, r, s, rs);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result got %h want 80000000", r); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL sll31_status got %h want 00", s); end
        do_op(4'd9, 32'h8000_0000, 32'd31, lat, r, s, rs);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL srl31_result got %h want 1", r); end
        do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, lat, r, s, rs);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL undef_result got %h want 0", r); end
        checks++; if (s !== 8'h80) begin errors++; $display("FAIL undef_status got %h want 80", s); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        test_shift_undef();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
